// File: rtl/store_pkg.sv
// Shared constants and types for the store packing path (store_pack_buffer).
// Buffer occupancy states and the packed-entry layout live here.
package store_pkg;

    localparam int ST_ADDR_W = 32;
    localparam int ST_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [ST_ADDR_W-1:0] addr;
        logic [ST_DATA_W-1:0] wdata;
        logic [3:0]           be;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store lane packer: size + low address bits -> byte enables and lane-shifted data.
// ALIGN_EXC_EN: flag misaligned/reserved stores instead of forcing the lane offset.
module store_lane_pack
    import store_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic        misalign
);

    logic [1:0]  lane;
    logic [3:0]  be_base;
    logic [31:0] payload;

    always_comb begin
        lane     = addr_lo;
        be_base  = BE_WORD;
        payload  = wdata_in;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_base = BE_BYTE;
                payload = {24'd0, wdata_in[7:0]};
            end
            SZ_HALF: begin
                be_base = BE_HALF;
                payload = {16'd0, wdata_in[15:0]};
`ifdef ALIGN_EXC_EN
                misalign = addr_lo[0];
`else
                lane = {addr_lo[1], 1'b0};
`endif
            end
            default: begin
                // word and reserved size both occupy all four lanes
                lane = 2'b00;
`ifdef ALIGN_EXC_EN
                misalign = (addr_lo != 2'b00) || (size == SZ_RSVD);
`endif
            end
        endcase
        be        = be_base << lane;
        wdata_out = payload << {lane, 3'b000};
    end

endmodule

// File: rtl/store_pack_buffer.sv
// Packs sb/sh/sw requests for data memory and holds them in a 2-entry skid buffer.
// ALIGN_EXC_EN: misaligned/reserved stores are dropped and reported on exc_ades/exc_badaddr.
module store_pack_buffer
    import store_pkg::*;
#(
    parameter int ADDR_W = ST_ADDR_W,
    parameter int DATA_W = ST_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] exc_badaddr,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat moves on a side only in a cycle where valid && ready are both
    // high at the rising edge; ready never depends combinationally on the other side.

    state_t state, state_next;
    entry_t head_q, skid_q, pk_entry;
    logic [3:0]  pk_be;
    logic [31:0] pk_wdata;
    logic        misalign;
    logic        accept, enq, xfer;
    logic        load_head_new, load_head_skid, load_skid;

    store_lane_pack u_pack (
        .addr_lo   (req_addr[1:0]),
        .size      (req_size),
        .wdata_in  (req_wdata),
        .be        (pk_be),
        .wdata_out (pk_wdata),
        .misalign  (misalign)
    );

    always_comb begin
        pk_entry       = '0;
        pk_entry.addr  = {req_addr[ADDR_W-1:2], 2'b00};
        pk_entry.wdata = pk_wdata;
        pk_entry.be    = pk_be;
    end

    assign req_ready = (state != ST_FULL);
    assign mem_valid = (state != ST_EMPTY);
    assign accept    = req_valid && req_ready;
    assign enq       = accept && !misalign;
    assign xfer      = mem_valid && mem_ready;
    assign mem_addr  = head_q.addr;
    assign mem_wdata = head_q.wdata;
    assign mem_be    = head_q.be;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_EMPTY;
        else          state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (enq) begin
                    state_next    = ST_ONE;
                    load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                // simultaneous accept and transfer replaces the head in place
                if (enq && xfer) begin
                    load_head_new = 1'b1;
                end else if (enq) begin
                    state_next = ST_FULL;
                    load_skid  = 1'b1;
                end else if (xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_next     = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_new)       head_q <= pk_entry;
            else if (load_head_skid) head_q <= skid_q;
            if (load_skid)           skid_q <= pk_entry;
        end
    end

`ifdef ALIGN_EXC_EN
    logic              exc_ades_q;
    logic [ADDR_W-1:0] exc_badaddr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_ades_q    <= 1'b0;
            exc_badaddr_q <= '0;
        end else begin
            exc_ades_q <= accept && misalign;
            if (accept && misalign) exc_badaddr_q <= req_addr;
        end
    end

    assign exc_ades    = exc_ades_q;
    assign exc_badaddr = exc_badaddr_q;
`else
    assign exc_ades    = 1'b0;
    assign exc_badaddr = '0;
`endif

endmodule

// File: tb/tb_store_pack_buffer.sv
// Directed bench for store_pack_buffer: packing table, skid/backpressure sequences,
// streaming throughput, reset mid-FULL, and the ALIGN_EXC_EN exception path.
module tb_store_pack_buffer;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_ades;
    logic [31:0] exc_badaddr;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    store_pack_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .exc_ades    (exc_ades),
        .exc_badaddr (exc_badaddr),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    logic        sb_on    = 1'b0;
    int          xfer_cnt = 0;
    int          first_x  = -1;
    int          last_x   = -1;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb);
        vec_t v;
        v.size = sz; v.addr = a; v.wdata = w;
        v.e_addr = ea; v.e_wdata = ew; v.e_be = eb;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
        req_valid = 1'b1;
        req_size  = sz;
        req_addr  = a;
        req_wdata = w;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: a transfer happens at the posedge following a negedge with valid && ready
    always @(negedge clk) begin
        if (sb_on && reset_n && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_xfer", mem_wdata, 32'hxxxxxxxx);
            end else begin
                check("sb_wdata", mem_wdata, exp_q.pop_front());
            end
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            xfer_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach end of test");
        $fatal(1);
    end

    initial begin
        int acc0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = SZ_BYTE;
        mem_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_exc_ades", exc_ades, 1'b0);
        check("rst_exc_badaddr", exc_badaddr, 32'h0);
        check("rst_state", dbg_state, ST_EMPTY);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);

        // packing table
        vecs.push_back(mk(SZ_BYTE, 32'h0000_1003, 32'h1122_33AB, 32'h0000_1000, 32'hAB00_0000, 4'b1000));
        vecs.push_back(mk(SZ_HALF, 32'h0000_2002, 32'hFFFF_5A5A, 32'h0000_2000, 32'h5A5A_0000, 4'b1100));
        vecs.push_back(mk(SZ_WORD, 32'h0000_2004, 32'h1234_5678, 32'h0000_2004, 32'h1234_5678, 4'b1111));
        vecs.push_back(mk(SZ_BYTE, 32'h0000_4000, 32'h0000_00C3, 32'h0000_4000, 32'h0000_00C3, 4'b0001));
        vecs.push_back(mk(SZ_BYTE, 32'h0000_4001, 32'hFFFF_FF7E, 32'h0000_4000, 32'h0000_7E00, 4'b0010));
        vecs.push_back(mk(SZ_BYTE, 32'h0000_4002, 32'h8765_43A5, 32'h0000_4000, 32'h00A5_0000, 4'b0100));
        vecs.push_back(mk(SZ_HALF, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0000_5000, 32'h0000_BEEF, 4'b0011));
        vecs.push_back(mk(SZ_WORD, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'b1111));
`ifndef ALIGN_EXC_EN
        vecs.push_back(mk(SZ_WORD, 32'h0000_3002, 32'h0BAD_F00D, 32'h0000_3000, 32'h0BAD_F00D, 4'b1111));
        vecs.push_back(mk(SZ_HALF, 32'h0000_5003, 32'h0000_1234, 32'h0000_5000, 32'h1234_0000, 4'b1100));
        vecs.push_back(mk(SZ_RSVD, 32'h0000_7002, 32'h89AB_CDEF, 32'h0000_7000, 32'h89AB_CDEF, 4'b1111));
`endif
        tick();
        mem_ready = 1'b1;
        foreach (vecs[i]) begin
            tick();
            drive(vecs[i].size, vecs[i].addr, vecs[i].wdata);
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), mem_valid, 1'b1);
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            check($sformatf("vec%0d_be", i), mem_be, vecs[i].e_be);
        end
        tick();
        @(negedge clk);
        check("table_drained", mem_valid, 1'b0);
        check("table_no_exc", exc_ades, 1'b0);

        // backpressure: three back-to-back sw into a stalled buffer
        tick();
        mem_ready = 1'b0;
        xfer_cnt = 0; first_x = -1; last_x = -1;
        sb_on = 1'b1;
        drive(SZ_WORD, 32'h0000_8000, 32'hA0A0_0001);
        exp_q.push_back(32'hA0A0_0001);
        tick();
        drive(SZ_WORD, 32'h0000_8004, 32'hB0B0_0002);
        exp_q.push_back(32'hB0B0_0002);
        @(negedge clk);
        check("bp_ready_one", req_ready, 1'b1);
        check("bp_valid_one", mem_valid, 1'b1);
        check("bp_head_one", mem_wdata, 32'hA0A0_0001);
        tick();
        drive(SZ_WORD, 32'h0000_8008, 32'hC0C0_0003);
        exp_q.push_back(32'hC0C0_0003);
        @(negedge clk);
        check("bp_ready_full", req_ready, 1'b0);
        check("bp_state_full", dbg_state, ST_FULL);
        check("bp_head_full", mem_wdata, 32'hA0A0_0001);
        tick();
        @(negedge clk);
        check("bp_hold_addr", mem_addr, 32'h0000_8000);
        check("bp_hold_wdata", mem_wdata, 32'hA0A0_0001);
        check("bp_hold_ready", req_ready, 1'b0);
        tick();
        mem_ready = 1'b1;
        tick();
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        check("bp_drained", mem_valid, 1'b0);
        check("bp_xfer_cnt", xfer_cnt, 3);
        check("bp_back_to_back", last_x - first_x, 2);
        check("bp_queue_empty", exp_q.size(), 0);

        // streaming: 8 stores with ready held high
        tick();
        xfer_cnt = 0; first_x = -1; last_x = -1;
        acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(SZ_WORD, 32'h0000_9000 + 32'(i * 4), 32'h5500_0000 + 32'(i * 32'h111));
            exp_q.push_back(32'h5500_0000 + 32'(i * 32'h111));
            tick();
            if (i == 0) acc0 = cyc;
        end
        req_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("stream_xfer_cnt", xfer_cnt, 8);
        check("stream_latency", first_x, acc0);
        check("stream_consecutive", last_x - first_x, 7);
        check("stream_queue_empty", exp_q.size(), 0);
        sb_on = 1'b0;

        // reset while FULL discards both entries
        tick();
        mem_ready = 1'b0;
        drive(SZ_BYTE, 32'h0000_A001, 32'h0000_0011);
        tick();
        drive(SZ_BYTE, 32'h0000_A002, 32'h0000_0022);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("rf_state_full", dbg_state, ST_FULL);
        #2;
        reset_n = 1'b0;
        #1;
        check("rf_async_valid", mem_valid, 1'b0);
        check("rf_async_be", mem_be, 4'h0);
        mem_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("rf_valid_after", mem_valid, 1'b0);
        check("rf_ready_after", req_ready, 1'b1);
        check("rf_exc_after", exc_ades, 1'b0);

`ifdef ALIGN_EXC_EN
        // misaligned word is swallowed and reported
        tick();
        drive(SZ_WORD, 32'h0000_3002, 32'h0BAD_F00D);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("exc_pulse", exc_ades, 1'b1);
        check("exc_badaddr", exc_badaddr, 32'h0000_3002);
        check("exc_no_enq", mem_valid, 1'b0);
        @(negedge clk);
        check("exc_pulse_end", exc_ades, 1'b0);
        check("exc_badaddr_hold", exc_badaddr, 32'h0000_3002);
        tick();
        drive(SZ_RSVD, 32'h0000_7000, 32'h89AB_CDEF);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("exc_rsvd_pulse", exc_ades, 1'b1);
        check("exc_rsvd_addr", exc_badaddr, 32'h0000_7000);
        check("exc_rsvd_no_enq", mem_valid, 1'b0);
`else
        check("noexc_badaddr", exc_badaddr, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
